// File: rtl/rocket_pkg.sv
// Shared definitions for the rocket launcher and the rocket motion controller.
package rocket_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD     = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_COOLDOWN = 2'd3
   } rocket_state_t;

   localparam int FIXED_POINT_MULTIPLIER = 64;
   localparam int SCREEN_WIDTH           = 640;
   localparam int SCREEN_HEIGHT          = 480;
   localparam int ROCKET_WIDTH_DEFAULT   = 16;

   // Saturate a 12-bit signed coordinate into the 11-bit signed range.
   function automatic logic signed [10:0] sat11(input logic signed [11:0] v);
      logic signed [10:0] r;
      if (v > 12'sd1023)
         r = 11'sh3FF;
      else if (v < -12'sd1024)
         r = 11'sh400;
      else
         r = v[10:0];
      return r;
   endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable down-counter of frame pulses; done_o flags the pulse that reaches zero.
module frame_countdown #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q;

   // Load takes priority, so a pulse coinciding with the load is not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else if (load_i)
         cnt_q <= load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_q <= cnt_q - 1'b1;
   end

   // Terminal count: this pulse takes the counter from 1 to 0.
   assign done_o = dec_i && !load_i && (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/single_h_rocket_launcher.sv
// Rocket lifecycle owner: fire detection, spawn computation, retirement,
// frame cooldown and ammunition budget.
module single_h_rocket_launcher
   import rocket_pkg::*;
#(
   parameter int ROCKET_SPEED    = 256,
   parameter int SHIP_WIDTH      = 32,
   parameter int ROCKET_WIDTH    = ROCKET_WIDTH_DEFAULT,
   parameter int Y_OFFSET        = 8,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int MAX_AMMO        = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               fireRequest,
   input  logic               reloadPulse,
   input  logic signed [10:0] shipTopLeftX,
   input  logic signed [10:0] shipTopLeftY,
   input  logic               shipSideToFace,
   input  logic               reachedBorder,
   input  logic               rocketHit,
   output logic               isActive,
   output logic signed [10:0] initialSpeed,
   output logic signed [10:0] initialX,
   output logic signed [10:0] initialY,
   output logic               launchPulse,
   output logic [3:0]         ammo,
   output logic               ready,
   output logic [1:0]         dbgState
);

   localparam int CD_W = 16;
   localparam logic signed [11:0] SHIP_W_S   = 12'(SHIP_WIDTH);
   localparam logic signed [11:0] ROCKET_W_S = 12'(ROCKET_WIDTH);
   localparam logic signed [11:0] Y_OFF_S    = 12'(Y_OFFSET);
   localparam logic signed [11:0] X_MAX_S    = 12'(SCREEN_WIDTH - 1 - ROCKET_WIDTH - 1);
   localparam logic signed [10:0] SPEED_S    = 11'(ROCKET_SPEED);
   localparam logic [3:0]         AMMO_FULL  = 4'(MAX_AMMO);
   localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COOLDOWN_FRAMES);
   localparam bit                 CD_SKIP    = (COOLDOWN_FRAMES == 0);

   rocket_state_t      state_q;
   logic               fire_q;
   logic               active_q;
   logic               launch_q;
   logic [3:0]         ammo_q;
   logic signed [10:0] speed_q;
   logic signed [10:0] x_q;
   logic signed [10:0] y_q;

   logic               fire_edge;
   logic               retire;
   logic               cd_load;
   logic               cd_dec;
   logic               cd_done;
   logic signed [11:0] x_raw;
   logic signed [11:0] x_clamped;
   logic signed [11:0] y_raw;
   logic signed [10:0] spawn_x_d;
   logic signed [10:0] spawn_y_d;
   logic signed [10:0] spawn_speed_d;

   assign fire_edge = fireRequest && !fire_q;
   assign retire    = reachedBorder || rocketHit;
   assign cd_load   = (state_q == ST_ACTIVE) && retire && !CD_SKIP;
   assign cd_dec    = (state_q == ST_COOLDOWN) && startOfFrame;

   // Spawn position and speed from the ship's current pose, in 12-bit signed.
   always_comb begin
      x_raw     = '0;
      x_clamped = '0;
      y_raw     = '0;
      if (shipSideToFace)
         x_raw = {shipTopLeftX[10], shipTopLeftX} - ROCKET_W_S;
      else
         x_raw = {shipTopLeftX[10], shipTopLeftX} + SHIP_W_S;
      if (x_raw < 12'sd0)
         x_clamped = 12'sd0;
      else if (x_raw > X_MAX_S)
         x_clamped = X_MAX_S;
      else
         x_clamped = x_raw;
      y_raw         = {shipTopLeftY[10], shipTopLeftY} + Y_OFF_S;
      spawn_x_d     = sat11(x_clamped);
      spawn_y_d     = sat11(y_raw);
      spawn_speed_d = shipSideToFace ? -SPEED_S : SPEED_S;
   end

   frame_countdown #(.W(CD_W)) u_cooldown (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cd_load),
      .load_val_i (CD_LOAD),
      .dec_i      (cd_dec),
      .done_o     (cd_done)
   );

   // Lifecycle FSM with registered launch outputs and ammo bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         fire_q   <= 1'b0;
         active_q <= 1'b0;
         launch_q <= 1'b0;
         ammo_q   <= AMMO_FULL;
         speed_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         fire_q   <= fireRequest;
         launch_q <= 1'b0;
         if (reloadPulse)
            ammo_q <= AMMO_FULL;
         case (state_q)
            ST_IDLE: begin
               if (fire_edge && (ammo_q != 4'd0))
                  state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               speed_q  <= spawn_speed_d;
               x_q      <= spawn_x_d;
               y_q      <= spawn_y_d;
               ammo_q   <= reloadPulse ? (AMMO_FULL - 4'd1) : (ammo_q - 4'd1);
               launch_q <= 1'b1;
               active_q <= 1'b1;
               state_q  <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (retire) begin
                  active_q <= 1'b0;
                  state_q  <= CD_SKIP ? ST_IDLE : ST_COOLDOWN;
               end
            end
            ST_COOLDOWN: begin
               if (cd_done)
                  state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign isActive     = active_q;
   assign launchPulse  = launch_q;
   assign initialSpeed = speed_q;
   assign initialX     = x_q;
   assign initialY     = y_q;
   assign ammo         = ammo_q;
   assign ready        = (state_q == ST_IDLE) && (ammo_q != 4'd0);
   assign dbgState     = state_q;

endmodule

// File: tb/tb_single_h_rocket_launcher.sv
// Directed and randomized bench for single_h_rocket_launcher.
module tb_single_h_rocket_launcher;

   localparam int SHIP_W   = 32;
   localparam int ROCKET_W = 16;
   localparam int Y_OFF    = 8;
   localparam int SPEED    = 256;
   localparam int CD       = 8;
   localparam int FULL     = 10;
   localparam int X_MAX    = 639 - ROCKET_W - 1;

   logic               clk;
   logic               reset;
   logic               startOfFrame;
   logic               fireRequest;
   logic               reloadPulse;
   logic signed [10:0] shipTopLeftX;
   logic signed [10:0] shipTopLeftY;
   logic               shipSideToFace;
   logic               reachedBorder;
   logic               rocketHit;
   logic               isActive;
   logic signed [10:0] initialSpeed;
   logic signed [10:0] initialX;
   logic signed [10:0] initialY;
   logic               launchPulse;
   logic [3:0]         ammo;
   logic               ready;
   logic [1:0]         dbgState;

   int checks = 0;
   int errors = 0;
   int model_ammo;
   int pulse_cnt = 0;
   int snap;
   int last_x, last_y, last_spd;

   single_h_rocket_launcher dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .fireRequest    (fireRequest),
      .reloadPulse    (reloadPulse),
      .shipTopLeftX   (shipTopLeftX),
      .shipTopLeftY   (shipTopLeftY),
      .shipSideToFace (shipSideToFace),
      .reachedBorder  (reachedBorder),
      .rocketHit      (rocketHit),
      .isActive       (isActive),
      .initialSpeed   (initialSpeed),
      .initialX       (initialX),
      .initialY       (initialY),
      .launchPulse    (launchPulse),
      .ammo           (ammo),
      .ready          (ready),
      .dbgState       (dbgState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (launchPulse === 1'b1) pulse_cnt++;

   // reference model: spawn rules from plain integer arithmetic
   function automatic int exp_x(input int x, input bit left);
      int v;
      v = left ? x - ROCKET_W : x + SHIP_W;
      if (v < 0) v = 0;
      if (v > X_MAX) v = X_MAX;
      return v;
   endfunction

   function automatic int exp_y(input int y);
      int v;
      v = y + Y_OFF;
      if (v > 1023) v = 1023;
      if (v < -1024) v = -1024;
      return v;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
         repeat ($urandom_range(2)) tick();
         tick();
      end
   endtask

   task automatic launch(input int x, input int y, input bit left, input bit keep_fire);
      shipTopLeftX   = 11'(x);
      shipTopLeftY   = 11'(y);
      shipSideToFace = left;
      fireRequest    = 1'b1;
      tick();
      check("load_not_active", int'(isActive), 0);
      tick();
      model_ammo--;
      last_x   = exp_x(x, left);
      last_y   = exp_y(y);
      last_spd = left ? -SPEED : SPEED;
      check("launch_active", int'(isActive), 1);
      check("launch_pulse", int'(launchPulse), 1);
      check("launch_x", int'(initialX), last_x);
      check("launch_y", int'(initialY), last_y);
      check("launch_speed", int'(initialSpeed), last_spd);
      check("launch_ammo", int'(ammo), model_ammo);
      if (!keep_fire) fireRequest = 1'b0;
      shipTopLeftX   = 11'(int'($urandom_range(600)));
      shipTopLeftY   = 11'(int'($urandom_range(400)));
      shipSideToFace = ~left;
      tick();
      check("pulse_one_cycle", int'(launchPulse), 0);
      check("hold_x", int'(initialX), last_x);
      check("hold_speed", int'(initialSpeed), last_spd);
   endtask

   task automatic retire(input bit border, input bit hit, input bit sof);
      reachedBorder = border;
      rocketHit     = hit;
      startOfFrame  = sof;
      tick();
      reachedBorder = 1'b0;
      rocketHit     = 1'b0;
      startOfFrame  = 1'b0;
      check("retire_inactive", int'(isActive), 0);
      check("retire_not_ready", int'(ready), 0);
   endtask

   task automatic cooldown_probe();
      frames(CD - 1);
      fireRequest = 1'b1;
      tick();
      tick();
      check("cd_fire_ignored", int'(isActive), 0);
      check("cd_ammo_kept", int'(ammo), model_ammo);
      fireRequest = 1'b0;
      tick();
      frames(1);
      check("cd_rearmed", int'(ready), (model_ammo > 0) ? 1 : 0);
   endtask

   // scoreboard-driven stimulus
   initial begin
      reset = 1'b1; startOfFrame = 1'b0; fireRequest = 1'b0; reloadPulse = 1'b0;
      shipTopLeftX = '0; shipTopLeftY = '0; shipSideToFace = 1'b0;
      reachedBorder = 1'b0; rocketHit = 1'b0;
      model_ammo = FULL;
      repeat (3) @(posedge clk);
      #1;
      check("rst_active", int'(isActive), 0);
      check("rst_x", int'(initialX), 0);
      check("rst_y", int'(initialY), 0);
      check("rst_speed", int'(initialSpeed), 0);
      check("rst_pulse", int'(launchPulse), 0);
      check("rst_ammo", int'(ammo), FULL);
      check("rst_ready", int'(ready), 1);
      reset = 1'b0;
      tick();

      // retire inputs while idle are ignored
      reachedBorder = 1'b1; rocketHit = 1'b1;
      tick();
      reachedBorder = 1'b0; rocketHit = 1'b0;
      tick();
      check("idle_retire_ignored", int'(ready), 1);

      // right-facing launch, border retirement, cooldown boundary
      snap = pulse_cnt;
      launch(100, 200, 1'b0, 1'b0);
      check("one_pulse", pulse_cnt - snap, 1);
      retire(1'b1, 1'b0, 1'b1);
      cooldown_probe();

      // left-facing clamp, simultaneous hit and border
      launch(5, 50, 1'b1, 1'b0);
      retire(1'b1, 1'b1, 1'b0);
      cooldown_probe();

      // reload in the LOAD cycle
      fireRequest = 1'b1;
      tick();
      reloadPulse = 1'b1;
      tick();
      reloadPulse = 1'b0;
      fireRequest = 1'b0;
      model_ammo = FULL - 1;
      check("reload_in_load_ammo", int'(ammo), model_ammo);
      check("reload_in_load_active", int'(isActive), 1);
      retire(1'b0, 1'b1, 1'b0);
      frames(CD);

      // held key across retirement and 100 frames
      snap = pulse_cnt;
      launch(300, 100, 1'b0, 1'b1);
      frames(20);
      retire(1'b1, 1'b0, 1'b0);
      frames(80);
      check("held_one_launch", pulse_cnt - snap, 1);
      check("held_idle_inactive", int'(isActive), 0);
      check("held_ready", int'(ready), 1);
      fireRequest = 1'b0;
      tick();

      // randomized launches
      for (int i = 0; i < 6; i++) begin
         int rx, ry;
         rx = int'($urandom_range(760)) - 60;
         ry = int'($urandom_range(2047)) - 1024;
         if (model_ammo == 0) begin
            reloadPulse = 1'b1; tick(); reloadPulse = 1'b0;
            model_ammo = FULL;
            check("rand_reload", int'(ammo), model_ammo);
         end
         launch(rx, ry, 1'($urandom_range(1)), 1'b0);
         frames($urandom_range(3));
         case ($urandom_range(2))
            0: retire(1'b1, 1'b0, 1'($urandom_range(1)));
            1: retire(1'b0, 1'b1, 1'($urandom_range(1)));
            default: retire(1'b1, 1'b1, 1'($urandom_range(1)));
         endcase
         frames(CD);
         tick();
      end

      // drain ammo, empty edges ignored, reload
      while (model_ammo > 0) begin
         launch(int'($urandom_range(620)), int'($urandom_range(470)), 1'($urandom_range(1)), 1'b0);
         retire(1'b1, 1'b0, 1'b0);
         frames(CD);
         tick();
      end
      check("empty_ammo", int'(ammo), 0);
      check("empty_not_ready", int'(ready), 0);
      fireRequest = 1'b1;
      tick();
      tick();
      check("empty_fire_ignored", int'(isActive), 0);
      fireRequest = 1'b0;
      tick();
      reloadPulse = 1'b1;
      tick();
      reloadPulse = 1'b0;
      model_ammo = FULL;
      check("reload_ammo", int'(ammo), FULL);
      check("reload_ready", int'(ready), 1);

      // asynchronous reset mid-ACTIVE
      launch(400, 300, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("arst_active", int'(isActive), 0);
      check("arst_x", int'(initialX), 0);
      check("arst_y", int'(initialY), 0);
      check("arst_speed", int'(initialSpeed), 0);
      check("arst_pulse", int'(launchPulse), 0);
      check("arst_ammo", int'(ammo), FULL);
      check("arst_ready", int'(ready), 1);
      tick();
      reset = 1'b0;
      model_ammo = FULL;
      tick();
      launch(600, 10, 1'b0, 1'b0);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
